// File: rtl/load_store_unit.sv
// RV32I data-memory stage: owns the word-organised data RAM, performs lane selection,
// byte-enabled stores and sign/zero-extended loads, and reports faulting accesses.
module load_store_unit #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]    state_r;
    logic [1:0]    state_next_s;
    logic          we_r;
    logic [2:0]    funct3_r;
    logic [AW+1:0] addr_r;
    logic [31:0]   wdata_r;
    logic          fault_r;
    logic [31:0]   mem_r [DEPTH];

    logic          accept_s;
    logic          misalign_s;
    logic          range_s;
    logic          width_s;
    logic          fault_s;
    logic [3:0]    be_s;
    logic [31:0]   lane_data_s;
    logic [31:0]   word_s;
    logic [7:0]    byte_s;
    logic [15:0]   half_s;
    logic [31:0]   load_data_s;
    logic          mem_we_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);

    // Fault classification of the incoming request, evaluated at accept time.
    always_comb begin
        misalign_s = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misalign_s = req_addr[0];
            2'b10:   misalign_s = (req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        range_s = ((req_addr >> (AW + 2)) != 32'd0);
        if (req_we) begin
            width_s = !((req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010));
        end else begin
            width_s = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        fault_s = misalign_s || range_s || width_s;
    end

    // Sequencing: IDLE -> ACCESS -> RESP -> IDLE.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_next_s = ST_RESP;
            ST_RESP:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Store byte enables and store data replicated onto every candidate lane.
    always_comb begin
        be_s        = 4'b0000;
        lane_data_s = wdata_r;
        case (funct3_r[1:0])
            2'b00: begin
                be_s        = 4'b0001 << addr_r[1:0];
                lane_data_s = {4{wdata_r[7:0]}};
            end
            2'b01: begin
                be_s        = addr_r[1] ? 4'b1100 : 4'b0011;
                lane_data_s = {2{wdata_r[15:0]}};
            end
            2'b10: begin
                be_s        = 4'b1111;
                lane_data_s = wdata_r;
            end
            default: begin
                be_s        = 4'b0000;
                lane_data_s = wdata_r;
            end
        endcase
    end

    // Load lane extraction and extension; stores and faults report zero.
    always_comb begin
        word_s      = mem_r[addr_r[AW+1:2]];
        byte_s      = word_s[{addr_r[1:0], 3'b000} +: 8];
        half_s      = addr_r[1] ? word_s[31:16] : word_s[15:0];
        load_data_s = 32'd0;
        if (we_r || fault_r) begin
            load_data_s = 32'd0;
        end else begin
            case (funct3_r)
                3'b000:  load_data_s = {{24{byte_s[7]}}, byte_s};
                3'b100:  load_data_s = {24'd0, byte_s};
                3'b001:  load_data_s = {{16{half_s[15]}}, half_s};
                3'b101:  load_data_s = {16'd0, half_s};
                3'b010:  load_data_s = word_s;
                default: load_data_s = 32'd0;
            endcase
        end
    end

    // Reset sampled at the ACCESS edge must suppress the write.
    assign mem_we_s = (state_r == ST_ACCESS) && we_r && !fault_r && !reset;

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[addr_r[AW+1:2]][8*i +: 8] <= lane_data_s[8*i +: 8];
                end
            end
        end
    end

    // Control state, request capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
            we_r       <= 1'b0;
            funct3_r   <= 3'd0;
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            req_ready  <= (state_next_s == ST_IDLE);
            resp_valid <= (state_r == ST_ACCESS);
            if (accept_s) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                addr_r   <= req_addr[AW+1:0];
                wdata_r  <= req_wdata;
                fault_r  <= fault_s;
            end
            if (state_r == ST_ACCESS) begin
                resp_rdata <= load_data_s;
                resp_fault <= fault_r;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-addressed reference model checked every cycle,
// plus literal expectations per transaction.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a flat byte memory of DEPTH*4 bytes.
    logic [7:0] mbytes [0:1023];
    int         m_busy = 0;       // cycles until the unit is free again
    bit         m_init = 1'b0;
    logic       exp_valid = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic       exp_fault = 1'b0;
    logic       t_we;
    logic [2:0] t_f3;
    logic [31:0] t_addr;
    logic [31:0] t_wd;

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
        bit bad_width;
        if (we) bad_width = (f3 > 3'd2);
        else    bad_width = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        return bad_width || (a >= 32'd1024) || ((a % acc_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = 32'd0;
        int n = acc_size(f3);
        for (int i = 0; i < n; i++) v = v | ({24'd0, mbytes[a + i]} << (8 * i));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    // Model timeline: accept, perform one cycle later, respond in the following cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_busy    <= 0;
            m_init    <= 1'b1;
            exp_valid <= 1'b0;
            exp_rdata <= 32'd0;
            exp_fault <= 1'b0;
        end else begin
            exp_valid <= 1'b0;
            if (m_busy == 0) begin
                if (req_valid) begin
                    t_we <= req_we; t_f3 <= req_funct3; t_addr <= req_addr; t_wd <= req_wdata;
                    m_busy <= 2;
                end
            end else if (m_busy == 2) begin
                if (is_fault(t_we, t_f3, t_addr)) begin
                    exp_fault <= 1'b1;
                    exp_rdata <= 32'd0;
                end else begin
                    exp_fault <= 1'b0;
                    if (t_we) begin
                        for (int i = 0; i < acc_size(t_f3); i++) mbytes[t_addr[9:0] + i] <= t_wd[8*i +: 8];
                        exp_rdata <= 32'd0;
                    end else begin
                        exp_rdata <= load_val(t_f3, t_addr);
                    end
                end
                exp_valid <= 1'b1;
                m_busy <= 1;
            end else begin
                m_busy <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_init) begin
            check("cyc req_ready", {31'd0, req_ready}, {31'd0, (m_busy == 0)});
            check("cyc resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
            check("cyc resp_fault", {31'd0, resp_fault}, {31'd0, exp_fault});
            if (!$isunknown(exp_rdata)) check("cyc resp_rdata", resp_rdata, exp_rdata);
        end
    end

    time acc_time;

    task automatic do_txn(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] er, input logic ef, input bit keep);
        bit acc = 1'b0;
        bit got = 1'b0;
        int n = 0;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        for (int k = 0; k < 10 && !acc; k++) begin
            @(negedge clk);
            if (req_ready) acc = 1'b1;
            @(posedge clk);
        end
        check({name, " accepted"}, {31'd0, acc}, 32'd1);
        acc_time = $time;
        #1;
        if (!keep) req_valid = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            n++;
            if (resp_valid) got = 1'b1;
        end
        check({name, " latency"}, n, 32'd2);
        check({name, " rdata"}, resp_rdata, er);
        check({name, " fault"}, {31'd0, resp_fault}, {31'd0, ef});
        check({name, " model rdata"}, exp_rdata, er);
    endtask

    time stream_t [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_fault", {31'd0, resp_fault}, 32'd0);

        do_txn("SW 10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        do_txn("LW 10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        do_txn("SB 13",  1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0, 1'b0, 1'b0);
        do_txn("LB 13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
        do_txn("LBU 13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 1'b0);
        do_txn("LW 10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 1'b0);
        do_txn("SH 12",  1'b1, 3'b001, 32'h12, 32'h00009234, 32'h0, 1'b0, 1'b0);
        do_txn("LH 12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF9234, 1'b0, 1'b0);
        do_txn("LHU 12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00009234, 1'b0, 1'b0);
        do_txn("SH 11",  1'b1, 3'b001, 32'h11, 32'h0000FFFF, 32'h0, 1'b1, 1'b0);
        do_txn("LW 10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h9234BEEF, 1'b0, 1'b0);
        do_txn("SW 20",  1'b1, 3'b010, 32'h20, 32'h5A5A1234, 32'h0, 1'b0, 1'b0);

        do_txn("LW 400",  1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1'b0);
        do_txn("SW 402",  1'b1, 3'b010, 32'h402, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        do_txn("LD f011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0);
        do_txn("ST f100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        do_txn("LW 10d",  1'b0, 3'b010, 32'h10, 32'h0, 32'h9234BEEF, 1'b0, 1'b0);
        do_txn("LW 20",   1'b0, 3'b010, 32'h20, 32'h0, 32'h5A5A1234, 1'b0, 1'b0);

        // Reset lands on the ACCESS edge of a store.
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h11111111;
        req_valid = 1'b1;
        @(negedge clk);
        check("rst pre ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst post ready", {31'd0, req_ready}, 32'd1);
        check("rst post valid", {31'd0, resp_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst no resp", {31'd0, resp_valid}, 32'd0);
        end
        do_txn("LW 20 after rst", 1'b0, 3'b010, 32'h20, 32'h0, 32'h5A5A1234, 1'b0, 1'b0);

        // Back-to-back stream with req_valid held high throughout.
        do_txn("S0 SB 21", 1'b1, 3'b000, 32'h21, 32'h0000007F, 32'h0, 1'b0, 1'b1);
        stream_t[0] = acc_time;
        do_txn("S1 LB 21", 1'b0, 3'b000, 32'h21, 32'h0, 32'h0000007F, 1'b0, 1'b1);
        stream_t[1] = acc_time;
        do_txn("S2 LH 22", 1'b0, 3'b001, 32'h22, 32'h0, 32'h00005A5A, 1'b0, 1'b1);
        stream_t[2] = acc_time;
        do_txn("S3 LW 20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h5A5A7F34, 1'b0, 1'b0);
        stream_t[3] = acc_time;
        for (int i = 1; i < 4; i++) begin
            check("stream spacing", 32'(stream_t[i] - stream_t[i-1]), 32'd30);
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
